// File: rtl/glm_op_sequencer.sv
// glm_op_sequencer: instruction sequencer for GLM operator units.
// Instructions (opcode, repeat count, five 32-bit config regs) are queued in a
// FIFO and launched one at a time on the unit selected by the opcode. Each
// launch is an op_start pulse answered by an op_done pulse from that unit.
// An instruction is issued 1 + repeat times and then retired.
// Handshake: an instruction transfers on any rising clk edge where
// instr_valid && instr_ready; instr_ready depends only on registered FIFO
// occupancy, never on instr_valid.
// Optional build macro GLM_OP_SEQUENCER_PERF_EN adds busy-cycle and
// last-instruction-cycle performance counters.
module glm_op_sequencer #(
   parameter int NUM_UNITS  = 4,
   parameter int OPCODE_W   = 4,
   parameter int LOG2_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [OPCODE_W-1:0]   instr_opcode,
   input  logic [15:0]           instr_repeat,
   input  logic [159:0]          instr_regs,
   output logic [NUM_UNITS-1:0]  op_start,
   input  logic [NUM_UNITS-1:0]  op_done,
   output logic [159:0]          op_regs,
   output logic                  busy,
   output logic [31:0]           num_completed,
   output logic                  error_bad_opcode,
`ifdef GLM_OP_SEQUENCER_PERF_EN
   output logic [47:0]           perf_busy_cycles,
   output logic [31:0]           perf_last_instr_cycles,
`endif
   output logic [1:0]            dbg_state
);

   localparam int DEPTH   = 1 << LOG2_DEPTH;
   localparam int ENTRY_W = OPCODE_W + 16 + 160;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [1:0]             state;
   logic [ENTRY_W-1:0]     fifo_mem [DEPTH];
   logic [LOG2_DEPTH-1:0]  wr_ptr;
   logic [LOG2_DEPTH-1:0]  rd_ptr;
   logic [LOG2_DEPTH:0]    count;
   logic                   push;
   logic                   pop;
   logic [ENTRY_W-1:0]     stg_entry;
   logic [OPCODE_W-1:0]    stg_opcode;
   logic [15:0]            stg_repeat;
   logic [159:0]           stg_regs;
   logic                   stg_bad;
   logic [OPCODE_W-1:0]    cur_opcode;
   logic [15:0]            cur_remaining;
   logic [NUM_UNITS-1:0]   sel_mask;
   logic                   done_hit;
   logic                   retire;

   assign instr_ready = (count < (LOG2_DEPTH+1)'(DEPTH));
   assign push        = instr_valid && instr_ready;
   assign pop         = (state == S_IDLE) && (count != '0);
   assign busy        = (state != S_IDLE) || (count != '0);
   assign dbg_state   = state;

   assign stg_opcode = stg_entry[ENTRY_W-1 -: OPCODE_W];
   assign stg_repeat = stg_entry[175:160];
   assign stg_regs   = stg_entry[159:0];
   assign stg_bad    = (32'(stg_opcode) >= 32'(NUM_UNITS));

   // Decode the active unit; start pulses and done matching both use this mask.
   always_comb begin
      sel_mask = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         sel_mask[i] = (cur_opcode == OPCODE_W'(i));
      end
   end

   assign op_start = ((state == S_ISSUE) && !reset) ? sel_mask : '0;
   assign done_hit = |(op_done & sel_mask);
   assign retire   = (state == S_WAIT) && done_hit && (cur_remaining == 16'd0);

   // FIFO storage; entries are not reset, occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {instr_opcode, instr_repeat, instr_regs};
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Hold the popped entry so a later push into the freed slot cannot corrupt it.
   always_ff @(posedge clk) begin
      if (reset) begin
         stg_entry <= '0;
      end else if (pop) begin
         stg_entry <= fifo_mem[rd_ptr];
      end
   end

   // Sequencer FSM: IDLE -> LOAD -> ISSUE <-> WAIT -> IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         cur_opcode       <= '0;
         cur_remaining    <= '0;
         op_regs          <= '0;
         num_completed    <= '0;
         error_bad_opcode <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (count != '0) state <= S_LOAD;
            end
            S_LOAD: begin
               cur_opcode    <= stg_opcode;
               cur_remaining <= stg_repeat;
               op_regs       <= stg_regs;
               if (stg_bad) begin
                  error_bad_opcode <= 1'b1;
                  state            <= S_IDLE;
               end else begin
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
            end
            default: begin
               if (done_hit) begin
                  if (cur_remaining == 16'd0) begin
                     num_completed <= num_completed + 32'd1;
                     state         <= S_IDLE;
                  end else begin
                     cur_remaining <= cur_remaining - 16'd1;
                     state         <= S_ISSUE;
                  end
               end
            end
         endcase
      end
   end

`ifdef GLM_OP_SEQUENCER_PERF_EN
   logic [31:0] instr_cycles;

   // Saturating count of every cycle spent outside IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_busy_cycles <= '0;
      end else if ((state != S_IDLE) && (perf_busy_cycles != '1)) begin
         perf_busy_cycles <= perf_busy_cycles + 48'd1;
      end
   end

   // Running per-instruction cycle count, restarted in LOAD (LOAD counts as 1).
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_cycles <= '0;
      end else if (state == S_LOAD) begin
         instr_cycles <= 32'd1;
      end else if ((state != S_IDLE) && (instr_cycles != '1)) begin
         instr_cycles <= instr_cycles + 32'd1;
      end
   end

   // Capture LOAD-to-final-op_done length, including the op_done cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_last_instr_cycles <= '0;
      end else if (retire) begin
         perf_last_instr_cycles <= (instr_cycles == '1) ? instr_cycles : instr_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_glm_op_sequencer.sv
// tb_glm_op_sequencer: self-checking bench for glm_op_sequencer.
// A table of single-instruction vectors plus hand-written sequences for FIFO
// fill, ignored op_done pulses and mid-operation reset. Launches are checked
// against a scoreboard queue of expected {op_start, op_regs} values.
module tb_glm_op_sequencer;

   localparam int NU   = 4;
   localparam int OW   = 4;
   localparam int SB_W = NU + 160;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           instr_valid;
   logic           instr_ready;
   logic [OW-1:0]  instr_opcode;
   logic [15:0]    instr_repeat;
   logic [159:0]   instr_regs;
   logic [NU-1:0]  op_start;
   logic [NU-1:0]  op_done;
   logic [159:0]   op_regs;
   logic           busy;
   logic [31:0]    num_completed;
   logic           error_bad_opcode;
   logic [1:0]     dbg_state;
`ifdef GLM_OP_SEQUENCER_PERF_EN
   logic [47:0]    perf_busy_cycles;
   logic [31:0]    perf_last_instr_cycles;
`endif

   logic [NU-1:0]  done_auto = '0;
   logic [NU-1:0]  done_man;
   assign op_done = done_auto | done_man;

   int cyc = 0;
   always @(posedge clk) cyc++;

   glm_op_sequencer #(.NUM_UNITS(NU), .OPCODE_W(OW), .LOG2_DEPTH(3)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .instr_valid            (instr_valid),
      .instr_ready            (instr_ready),
      .instr_opcode           (instr_opcode),
      .instr_repeat           (instr_repeat),
      .instr_regs             (instr_regs),
      .op_start               (op_start),
      .op_done                (op_done),
      .op_regs                (op_regs),
      .busy                   (busy),
      .num_completed          (num_completed),
      .error_bad_opcode       (error_bad_opcode),
`ifdef GLM_OP_SEQUENCER_PERF_EN
      .perf_busy_cycles       (perf_busy_cycles),
      .perf_last_instr_cycles (perf_last_instr_cycles),
`endif
      .dbg_state              (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [SB_W-1:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- unit model and launch monitor ----------------
   int lat           = 3;
   bit auto_en       = 1'b1;
   int gap_exp       = 0;
   int ucnt [NU]     = '{default: 0};
   int last_done_cyc = -1;
   int last_start_cyc = -1;
   int first_start_cyc = -1;
   int push_cyc      = 0;
   int n_starts      = 0;

   always @(negedge clk) begin
      logic [SB_W-1:0] e;
      for (int u = 0; u < NU; u++) begin
         done_auto[u] = 1'b0;
         if (ucnt[u] > 0) begin
            ucnt[u]--;
            if (ucnt[u] == 0) begin
               done_auto[u]  = 1'b1;
               last_done_cyc = cyc;
            end
         end
         if (auto_en && op_start[u]) ucnt[u] = lat;
      end
      if (op_start != '0) begin
         n_starts++;
         if (last_start_cyc < push_cyc) first_start_cyc = cyc;
         if (gap_exp != 0 && last_done_cyc > last_start_cyc && last_done_cyc >= push_cyc)
            check("done_to_start_gap", 192'(cyc - last_done_cyc), 192'(gap_exp));
         last_start_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_op_start", 192'({op_start, op_regs}), 192'(0));
         end else begin
            e = exp_q.pop_front();
            check("op_start_and_regs", 192'({op_start, op_regs}), 192'(e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_instr(input logic [OW-1:0] opc, input logic [15:0] rpt, input logic [159:0] regs);
      int n = 0;
      logic [NU-1:0] oh;
      @(negedge clk);
      instr_valid  = 1'b1;
      instr_opcode = opc;
      instr_repeat = rpt;
      instr_regs   = regs;
      while (!instr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("push_ready_timeout", 192'(n < 200), 192'(1));
      push_cyc = cyc + 1;
      if (32'(opc) < NU) begin
         oh = NU'(1) << opc;
         for (int k = 0; k <= int'(rpt); k++) exp_q.push_back({oh, regs});
      end
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("busy_clears", 192'(busy), 192'(0));
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [OW-1:0] opcode;
      logic [15:0]   rpt;
      logic [31:0]   regs0;
      int            lat;
      int            exp_starts;
      int            exp_inc;
      logic          exp_err;
   } vec_t;

   vec_t         vecs [6];
   logic [159:0] t_regs;
   int           s0;
   int           exp_completed = 0;
   int           n;

   initial begin
      vecs[0] = '{4'd1,  16'd0, 32'h0004_0010, 20, 1, 1, 1'b0};
      vecs[1] = '{4'd2,  16'd3, 32'hA5A5_0002,  5, 4, 1, 1'b0};
      vecs[2] = '{4'd7,  16'd2, 32'hDEAD_0007,  3, 0, 0, 1'b1};
      vecs[3] = '{4'd0,  16'd0, 32'h1234_5678,  3, 1, 1, 1'b1};
      vecs[4] = '{4'd3,  16'd1, $urandom(), int'($urandom_range(6, 1)), 2, 1, 1'b1};
      vecs[5] = '{4'd15, 16'd0, 32'hBEEF_000F,  2, 0, 0, 1'b1};

      reset        = 1'b1;
      instr_valid  = 1'b0;
      instr_opcode = '0;
      instr_repeat = '0;
      instr_regs   = '0;
      done_man     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_op_start", 192'(op_start), 192'(0));
      check("rst_op_regs", 192'(op_regs), 192'(0));
      check("rst_num_completed", 192'(num_completed), 192'(0));
      check("rst_error", 192'(error_bad_opcode), 192'(0));
      check("rst_busy", 192'(busy), 192'(0));
      check("rst_instr_ready", 192'(instr_ready), 192'(1));
      check("rst_state", 192'(dbg_state), 192'(0));

      // Table: one instruction at a time from an empty, idle sequencer
      for (int i = 0; i < 6; i++) begin
         t_regs  = {$urandom(), $urandom(), $urandom(), $urandom(), vecs[i].regs0};
         lat     = vecs[i].lat;
         gap_exp = 1;
         s0      = n_starts;
         push_instr(vecs[i].opcode, vecs[i].rpt, t_regs);
         wait_idle(2000);
         exp_completed += vecs[i].exp_inc;
         check("vec_start_count", 192'(n_starts - s0), 192'(vecs[i].exp_starts));
         if (vecs[i].exp_starts > 0)
            check("vec_launch_latency", 192'(first_start_cyc - push_cyc), 192'(2));
         check("vec_num_completed", 192'(num_completed), 192'(exp_completed));
         check("vec_error_bad_opcode", 192'(error_bad_opcode), 192'(vecs[i].exp_err));
         check("vec_op_regs_held", 192'(op_regs), 192'(t_regs));
         check("vec_scoreboard_drained", 192'(exp_q.size()), 192'(0));
`ifdef GLM_OP_SEQUENCER_PERF_EN
         if (vecs[i].exp_inc == 1)
            check("vec_perf_last", 192'(perf_last_instr_cycles),
                  192'(1 + (int'(vecs[i].rpt) + 1) * (vecs[i].lat + 1)));
`endif
      end

      // FIFO fill: 9 back-to-back pushes while unit 0 is slow
      lat     = 30;
      gap_exp = 3;
      s0      = n_starts;
      for (int i = 0; i < 9; i++) begin
         t_regs = {$urandom(), $urandom(), $urandom(), $urandom(), 32'h3000_0000 + 32'(i)};
         push_instr(4'd0, 16'd0, t_regs);
      end
      @(negedge clk);
      check("fill_ready_low", 192'(instr_ready), 192'(0));
      check("fill_busy", 192'(busy), 192'(1));
      wait_idle(3000);
      exp_completed += 9;
      check("fill_start_count", 192'(n_starts - s0), 192'(9));
      check("fill_num_completed", 192'(num_completed), 192'(exp_completed));
      check("fill_scoreboard_drained", 192'(exp_q.size()), 192'(0));

      // op_done on other units, and during ISSUE, is ignored
      auto_en = 1'b0;
      gap_exp = 0;
      s0      = n_starts;
      t_regs  = {$urandom(), $urandom(), $urandom(), $urandom(), 32'h5555_0003};
      push_instr(4'd3, 16'd0, t_regs);
      n = 0;
      @(negedge clk);
      while (op_start[3] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ign_start_seen", 192'(n < 20), 192'(1));
      done_man = 4'b1000;
      @(negedge clk);
      done_man = 4'b0000;
      check("ign_done_in_issue", 192'(dbg_state), 192'(3));
      done_man = 4'b0011;
      @(negedge clk);
      done_man = 4'b0000;
      check("ign_other_units_state", 192'(dbg_state), 192'(3));
      check("ign_other_units_count", 192'(num_completed), 192'(exp_completed));
      repeat (2) @(negedge clk);
      check("ign_still_busy", 192'(busy), 192'(1));
      done_man = 4'b1000;
      @(negedge clk);
      done_man = 4'b0000;
      exp_completed += 1;
      check("ign_retire_count", 192'(num_completed), 192'(exp_completed));
      check("ign_retire_state", 192'(dbg_state), 192'(0));
      check("ign_single_start", 192'(n_starts - s0), 192'(1));

      // Reset during WAIT with three queued instructions
      push_instr(4'd2, 16'd5, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      for (int i = 0; i < 3; i++)
         push_instr(4'd1, 16'd0, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      @(negedge clk);
      check("rstw_in_wait", 192'(dbg_state), 192'(3));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      exp_completed = 0;
      s0 = n_starts;
      check("rstw_busy", 192'(busy), 192'(0));
      check("rstw_instr_ready", 192'(instr_ready), 192'(1));
      check("rstw_num_completed", 192'(num_completed), 192'(0));
      check("rstw_error", 192'(error_bad_opcode), 192'(0));
      check("rstw_op_regs", 192'(op_regs), 192'(0));
      check("rstw_state", 192'(dbg_state), 192'(0));
`ifdef GLM_OP_SEQUENCER_PERF_EN
      check("rstw_perf_busy", 192'(perf_busy_cycles), 192'(0));
      check("rstw_perf_last", 192'(perf_last_instr_cycles), 192'(0));
`endif
      done_man = 4'b0100;
      @(negedge clk);
      done_man = 4'b0000;
      repeat (4) @(negedge clk);
      check("rstw_late_done_starts", 192'(n_starts - s0), 192'(0));
      check("rstw_late_done_count", 192'(num_completed), 192'(0));
      check("rstw_late_done_busy", 192'(busy), 192'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "time limit");
   end

endmodule
